// File: rtl/fwl_pkg.sv
// Shared types and constants for the flowing_water_lights front end.
package fwl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int SW_BUS_W                = 3;

endpackage

// File: rtl/bit_synchronizer.sv
// Single-bit multi-flop synchroniser for asynchronous board inputs.
module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces the board button and switches feeding flowing_water_lights.
module input_conditioner
  import fwl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_raw,
  input  logic [1:0] freq_raw,
  input  logic       dir_raw,
  output logic       button,
  output logic       button_level,
  output logic [1:0] freq_set,
  output logic       dir_set
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                btn_sync;
  logic [SW_BUS_W-1:0] sw_sync;

  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_btn (
    .clk(clk), .rst(rst), .d(button_raw), .q(btn_sync)
  );
  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_freq1 (
    .clk(clk), .rst(rst), .d(freq_raw[1]), .q(sw_sync[2])
  );
  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_freq0 (
    .clk(clk), .rst(rst), .d(freq_raw[0]), .q(sw_sync[1])
  );
  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dir (
    .clk(clk), .rst(rst), .d(dir_raw), .q(sw_sync[0])
  );

  // Button debounce FSM: press and release each need DEBOUNCE_CYCLES matching samples.
  btn_state_t       state, state_next;
  logic [CNT_W-1:0] btn_cnt, btn_cnt_next;
  logic             pulse_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    state_next   = state;
    btn_cnt_next = btn_cnt;
    pulse_next   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_next   = PRESS_CHK;
          btn_cnt_next = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (!btn_sync) begin
          state_next   = IDLE;
          btn_cnt_next = '0;
        end else if (btn_cnt == CNT_LAST) begin
          state_next   = HELD;
          btn_cnt_next = '0;
          pulse_next   = 1'b1;
        end else begin
          btn_cnt_next = btn_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_next   = REL_CHK;
          btn_cnt_next = CNT_ONE;
        end
      end
      REL_CHK: begin
        if (btn_sync) begin
          state_next   = HELD;
          btn_cnt_next = '0;
        end else if (btn_cnt == CNT_LAST) begin
          state_next   = IDLE;
          btn_cnt_next = '0;
        end else begin
          btn_cnt_next = btn_cnt + CNT_ONE;
        end
      end
      default: begin
        state_next   = IDLE;
        btn_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      btn_cnt <= '0;
      button  <= 1'b0;
    end else begin
      state   <= state_next;
      btn_cnt <= btn_cnt_next;
      button  <= pulse_next;
    end
  end

  // Release bounce keeps the level up until the release is accepted.
  assign button_level = (state == HELD) || (state == REL_CHK);

  // Switch debouncer: the whole bus must hold one value before the outputs follow it.
  logic [SW_BUS_W-1:0] sw_cand, sw_out;
  logic [CNT_W-1:0]    sw_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_cand <= '0;
      sw_cnt  <= '0;
      sw_out  <= '0;
    end else if (sw_sync != sw_cand) begin
      sw_cand <= sw_sync;
      sw_cnt  <= '0;
    end else if (sw_cand != sw_out) begin
      if (sw_cnt == CNT_LAST) begin
        sw_out <= sw_cand;
        sw_cnt <= '0;
      end else begin
        sw_cnt <= sw_cnt + CNT_ONE;
      end
    end else begin
      sw_cnt <= '0;
    end
  end

  assign {freq_set, dir_set} = sw_out;

endmodule
